// File: rtl/scene_renderer_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scene_renderer_if: VGA pixel read bus between controller/renderer |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface scene_renderer_if;
  logic        rdn;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        vs;
  logic [11:0] vga_data;

  modport master (output rdn, output row_addr, output col_addr, output vs, input vga_data);
  modport slave  (input rdn, input row_addr, input col_addr, input vs, output vga_data);
endinterface
`default_nettype wire

// File: rtl/scene_renderer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | scene_renderer: per-pixel colour source for the dinosaur game.     |
// | Optional collision FSM: SCENE_COLLISION_EN.        Rev 1.0        |
// +------------------------------------------------------------------+
module scene_renderer #(
  parameter int GROUND_ROW = 400,
  parameter int DINO_COL   = 80
) (
  input  logic             CLK,
  input  logic             clrn,
  scene_renderer_if.slave  bus,
  input  logic [5:0]       dinosaur_height,
  input  logic [5:0]       ground_position,
  input  logic             game_status,
  output logic             collision,
  output logic             frame_tick
);

  localparam logic [9:0] c_dino_lo  = 10'(DINO_COL);
  localparam logic [9:0] c_dino_hi  = 10'(DINO_COL + 19);
  localparam logic [9:0] c_top_base = 10'(GROUND_ROW - 40);
  localparam logic [9:0] c_cact_lo  = 10'(GROUND_ROW - 32);
  localparam logic [9:0] c_cact_hi  = 10'(GROUND_ROW - 1);
  localparam logic [9:0] c_gnd_lo   = 10'(GROUND_ROW);
  localparam logic [9:0] c_gnd_hi   = 10'(GROUND_ROW + 3);
  localparam logic [7:0] c_cact_ph  = 8'd232;

  logic        r_vs_q;
  logic [5:0]  r_h_q;
  logic [5:0]  r_g_q;
  logic        r_over_q;
  logic [3:0]  r_blink_cnt;
  logic        r_frame_tick;
  logic [11:0] r_vga_data;

  logic        w_frame;
  logic [9:0]  w_row;
  logic [9:0]  w_top;
  logic [9:0]  w_bot;
  logic [7:0]  w_s_lo;
  logic        w_dino;
  logic        w_cactus;
  logic        w_ground;
  logic [11:0] w_pix;

  assign w_frame = bus.vs & ~r_vs_q;
  assign w_row   = {1'b0, bus.row_addr};
  assign w_top   = c_top_base - {2'b00, r_h_q, 2'b00};
  assign w_bot   = w_top + 10'd39;

  // Cactus phase only needs (col + 10*g) mod 256, so the sum is kept at 8 bits.
  assign w_s_lo  = bus.col_addr[7:0] + {r_g_q[4:0], 3'b000} + {1'b0, r_g_q, 1'b0};

  assign w_dino   = (bus.col_addr >= c_dino_lo) && (bus.col_addr <= c_dino_hi) &&
                    (w_row >= w_top) && (w_row <= w_bot);
  assign w_cactus = (w_s_lo >= c_cact_ph) && (w_row >= c_cact_lo) && (w_row <= c_cact_hi);
  assign w_ground = (w_row >= c_gnd_lo) && (w_row <= c_gnd_hi);

  always_comb begin
    w_pix = 12'hFFF;
    if (bus.rdn) begin
      w_pix = 12'h000;
    end else if (w_dino && !(r_over_q && r_blink_cnt[3])) begin
      w_pix = r_over_q ? 12'hF00 : 12'h333;
    end else if (w_cactus) begin
      w_pix = 12'h0A0;
    end else if (w_ground) begin
      w_pix = 12'h555;
    end
  end

  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      r_vs_q       <= 1'b0;
      r_h_q        <= 6'd0;
      r_g_q        <= 6'd0;
      r_over_q     <= 1'b0;
      r_blink_cnt  <= 4'd0;
      r_frame_tick <= 1'b0;
      r_vga_data   <= 12'h000;
    end else begin
      r_vs_q       <= bus.vs;
      r_frame_tick <= w_frame;
      r_vga_data   <= w_pix;
      if (w_frame) begin
        r_h_q       <= dinosaur_height;
        r_g_q       <= ground_position;
        r_over_q    <= ~game_status;
        r_blink_cnt <= r_blink_cnt + 4'd1;
      end
    end
  end

  assign bus.vga_data = r_vga_data;
  assign frame_tick   = r_frame_tick;

`ifdef SCENE_COLLISION_EN
  localparam logic [1:0] c_idle   = 2'd0;
  localparam logic [1:0] c_hit    = 2'd1;
  localparam logic [1:0] c_report = 2'd2;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       w_overlap;
  logic       r_collision;

  assign w_overlap = ~bus.rdn & w_dino & w_cactus & ~r_over_q;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:   if (w_overlap) w_state_nxt = c_hit;
      c_hit:    if (w_frame) w_state_nxt = c_report;
      c_report: w_state_nxt = w_overlap ? c_hit : c_idle;
      default:  w_state_nxt = c_idle;
    endcase
  end

  // The pulse follows the REPORT state by one cycle, landing just after frame_tick.
  always_ff @(posedge CLK or negedge clrn) begin
    if (!clrn) begin
      r_state     <= c_idle;
      r_collision <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_collision <= (r_state == c_report);
    end
  end

  assign collision = r_collision;
`else
  assign collision = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_scene_renderer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_scene_renderer: self-checking bench with a pixel scoreboard.   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_scene_renderer;

`ifdef SCENE_COLLISION_EN
  localparam bit COLL_EN = 1'b1;
`else
  localparam bit COLL_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       clrn;
  logic [5:0] dinosaur_height;
  logic [5:0] ground_position;
  logic       game_status;
  logic       collision;
  logic       frame_tick;

  scene_renderer_if bus();

  scene_renderer dut (
    .CLK             (CLK),
    .clrn            (clrn),
    .bus             (bus),
    .dinosaur_height (dinosaur_height),
    .ground_position (ground_position),
    .game_status     (game_status),
    .collision       (collision),
    .frame_tick      (frame_tick)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  logic [11:0] exp_q[$];
  logic [11:0] exp_pix;

  // Reference state the bench tracks alongside the DUT
  logic [5:0] m_h = 0;
  logic [5:0] m_g = 0;
  logic       m_over = 0;
  logic [3:0] m_blink = 0;
  logic       m_pending = 0;

  function automatic bit is_dino(int row, int col);
    int top = 360 - 4 * int'(m_h);
    return (col >= 80) && (col < 100) && (row >= top) && (row < top + 40);
  endfunction

  function automatic bit is_cact(int row, int col);
    return (((col + 10 * int'(m_g)) % 256) >= 232) && (row >= 368) && (row < 400);
  endfunction

  function automatic logic [11:0] model_pix(int row, int col, bit rdn_v);
    if (rdn_v) return 12'h000;
    if (is_dino(row, col) && !(m_over && m_blink[3])) return m_over ? 12'hF00 : 12'h333;
    if (is_cact(row, col)) return 12'h0A0;
    if (row >= 400 && row < 404) return 12'h555;
    return 12'hFFF;
  endfunction

  // Drives one pixel request and pushes its predicted colour; returns just after the sampling edge.
  task automatic drive_pix(input int row, input int col, input bit rdn_v);
    @(negedge CLK);
    bus.rdn      = rdn_v;
    bus.row_addr = 9'(row);
    bus.col_addr = 10'(col);
    exp_q.push_back(model_pix(row, col, rdn_v));
    if (!rdn_v && is_dino(row, col) && is_cact(row, col) && !m_over) m_pending = 1'b1;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_frame(input logic [5:0] h, input logic [5:0] g, input bit st, input string tag);
    bit exp_c;
    @(negedge CLK);
    bus.rdn = 1'b1; bus.vs = 1'b1;
    dinosaur_height = h; ground_position = g; game_status = st;
    @(posedge CLK);
    #1;
    m_h = h; m_g = g; m_over = !st; m_blink = m_blink + 4'd1;
    exp_c = COLL_EN ? m_pending : 1'b0;
    m_pending = 1'b0;
    total++;
    if (frame_tick !== 1'b1) begin bad++; $display("FAIL %s frame_tick got=%b want=1", tag, frame_tick); end
    @(negedge CLK);
    bus.vs = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (collision !== exp_c) begin bad++; $display("FAIL %s collision got=%b want=%b", tag, collision, exp_c); end
    total++;
    if (frame_tick !== 1'b0) begin bad++; $display("FAIL %s tick_clear got=%b want=0", tag, frame_tick); end
    @(posedge CLK);
    #1;
    total++;
    if (collision !== 1'b0) begin bad++; $display("FAIL %s coll_clear got=%b want=0", tag, collision); end
  endtask

  task automatic test_reset;
    clrn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.rdn = 1'($urandom); bus.vs = 1'($urandom);
      bus.row_addr = 9'($urandom); bus.col_addr = 10'($urandom);
      dinosaur_height = 6'($urandom); ground_position = 6'($urandom); game_status = 1'($urandom);
      @(posedge CLK);
      #1;
      total++;
      if (bus.vga_data !== 12'h000) begin bad++; $display("FAIL reset_vga got=%h want=000", bus.vga_data); end
      total++;
      if (collision !== 1'b0) begin bad++; $display("FAIL reset_coll got=%b want=0", collision); end
      total++;
      if (frame_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", frame_tick); end
    end
    @(negedge CLK);
    bus.vs = 1'b0; bus.rdn = 1'b1;
    dinosaur_height = 0; ground_position = 0; game_status = 1'b1;
    clrn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_pix(380, 85, 1'b1);
      exp_pix = exp_q.pop_front();
      total++;
      if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL reset_rdn got=%h want=%h", bus.vga_data, exp_pix); end
    end
  endtask

  task automatic test_static;
    int pr[14] = '{380, 401, 370, 100, 359, 360, 399, 380, 380, 403, 404, 367, 370, 370};
    int pc[14] = '{ 85, 300, 235,  10,  85,  80,  99, 100,  79,   0,   0, 235, 255, 256};
    do_frame(6'd0, 6'd0, 1'b1, "static_frame");
    for (int i = 0; i < 14; i++) begin
      drive_pix(pr[i], pc[i], 1'b0);
      exp_pix = exp_q.pop_front();
      total++;
      if (bus.vga_data !== exp_pix)
        begin bad++; $display("FAIL static(%0d,%0d) got=%h want=%h", pr[i], pc[i], bus.vga_data, exp_pix); end
    end
    drive_pix(380, 85, 1'b1);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL static_rdn got=%h want=%h", bus.vga_data, exp_pix); end
  endtask

  task automatic test_frame_latch;
    do_frame(6'd0, 6'd0, 1'b1, "latch_frame0");
    @(negedge CLK);
    dinosaur_height = 6'd10; ground_position = 6'd7;
    drive_pix(380, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL latch_hold got=%h want=%h", bus.vga_data, exp_pix); end
    do_frame(6'd10, 6'd0, 1'b1, "latch_frame1");
    drive_pix(380, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL latch_old got=%h want=%h", bus.vga_data, exp_pix); end
    drive_pix(330, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL latch_new got=%h want=%h", bus.vga_data, exp_pix); end
  endtask

  task automatic test_scroll;
    int pr[6] = '{370, 370, 108, 107, 370, 500};
    int pc[6] = '{202, 201,  80,  80, 114, 700};
    do_frame(6'd0, 6'd3, 1'b1, "scroll_frame");
    for (int i = 0; i < 2; i++) begin
      drive_pix(pr[i], pc[i], 1'b0);
      exp_pix = exp_q.pop_front();
      total++;
      if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL scroll(%0d,%0d) got=%h want=%h", pr[i], pc[i], bus.vga_data, exp_pix); end
    end
    do_frame(6'd63, 6'd63, 1'b1, "scroll_max");
    for (int i = 2; i < 6; i++) begin
      drive_pix(pr[i], pc[i], 1'b0);
      exp_pix = exp_q.pop_front();
      total++;
      if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL scroll_max(%0d,%0d) got=%h want=%h", pr[i], pc[i], bus.vga_data, exp_pix); end
    end
    do_frame(6'd0, 6'd0, 1'b1, "scroll_zero");
    drive_pix(370, 1000, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL scroll_oor got=%h want=%h", bus.vga_data, exp_pix); end
  endtask

  task automatic test_collision;
    do_frame(6'd0, 6'd2, 1'b1, "coll_setup");
    drive_pix(380, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL coll_miss_pix got=%h want=%h", bus.vga_data, exp_pix); end
    do_frame(6'd0, 6'd15, 1'b1, "coll_none");
    drive_pix(380, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL coll_hit_pix got=%h want=%h", bus.vga_data, exp_pix); end
    do_frame(6'd0, 6'd15, 1'b1, "coll_pulse");
  endtask

  task automatic test_back_to_back;
    // Overlap scanned in consecutive frames must pulse every frame.
    for (int f = 0; f < 2; f++) begin
      drive_pix(370, 90, 1'b0);
      drive_pix(375, 230, 1'b0);
      drive_pix(401, 85, 1'b0);
      for (int k = 0; k < 3; k++) begin
        exp_pix = exp_q.pop_front();
        total++;
        if (bus.vga_data !== exp_pix && k == 2) begin bad++; $display("FAIL b2b_pix got=%h want=%h", bus.vga_data, exp_pix); end
      end
      do_frame(6'd0, 6'd15, 1'b1, "b2b_pulse");
    end
  endtask

  task automatic test_blink;
    for (int i = 0; i < 16; i++) begin
      do_frame(6'd0, (i % 2 == 1) ? 6'd15 : 6'd0, 1'b0, "blink_frame");
      drive_pix(380, 85, 1'b0);
      exp_pix = exp_q.pop_front();
      total++;
      if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL blink[%0d] got=%h want=%h", i, bus.vga_data, exp_pix); end
    end
    do_frame(6'd0, 6'd0, 1'b1, "blink_end");
    // Mid-frame asynchronous reset
    drive_pix(380, 85, 1'b0);
    void'(exp_q.pop_front());
    #2 clrn = 1'b0;
    #1;
    total++;
    if (bus.vga_data !== 12'h000) begin bad++; $display("FAIL midrst_vga got=%h want=000", bus.vga_data); end
    total++;
    if (collision !== 1'b0 || frame_tick !== 1'b0) begin bad++; $display("FAIL midrst_flags got=%b%b want=00", collision, frame_tick); end
    @(negedge CLK);
    clrn = 1'b1;
    dinosaur_height = 6'd20; ground_position = 6'd9;
    m_h = 0; m_g = 0; m_over = 0; m_blink = 0; m_pending = 0;
    drive_pix(380, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL midrst_pix got=%h want=%h", bus.vga_data, exp_pix); end
    do_frame(6'd0, 6'd0, 1'b0, "midrst_frame");
    drive_pix(380, 85, 1'b0);
    exp_pix = exp_q.pop_front();
    total++;
    if (bus.vga_data !== exp_pix) begin bad++; $display("FAIL midrst_blink got=%h want=%h", bus.vga_data, exp_pix); end
  endtask

  initial begin
    clrn = 1'b0;
    bus.rdn = 1'b1; bus.vs = 1'b0; bus.row_addr = 0; bus.col_addr = 0;
    dinosaur_height = 0; ground_position = 0; game_status = 1'b1;
    test_reset();
    test_static();
    test_frame_latch();
    test_scroll();
    test_collision();
    test_back_to_back();
    test_blink();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
